// File: rtl/lo_channel_sequencer.sv
// Sequences the quadrature LO across the enabled analysis channels.
// Per channel: select tap, pulse LO reset, settle, measure, then hand off via req/ack.
module lo_channel_sequencer #(
  parameter int NCH       = 16,
  parameter int DWELL_W   = 16,
  parameter int SETTLE_W  = 8,
  parameter int LORST_CYC = 3,
  localparam int CW       = $clog2(NCH)
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                cfg_we,
  input  logic [CW-1:0]       cfg_addr,
  input  logic                cfg_en,
  input  logic [3:0]          cfg_tap,
  input  logic [DWELL_W-1:0]  dwell,
  input  logic [SETTLE_W-1:0] settle,
  input  logic                cont,
  input  logic                start,
  input  logic                stop,
  input  logic                done_ack,
  output logic                lo_rst,
  output logic [3:0]          tap_sel,
  output logic [CW-1:0]       ch_idx,
  output logic                meas_valid,
  output logic                done_req,
  output logic                busy,
  output logic                scan_done
);

  localparam int CNT_W = (DWELL_W > SETTLE_W) ? DWELL_W : SETTLE_W;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CW:0]      PTR_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FIND, S_LORST, S_SETTLE, S_DWELL, S_HANDOFF
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [CW:0]         ptr, ptr_nxt;
  logic [DWELL_W-1:0]  dwell_q;
  logic [SETTLE_W-1:0] settle_q;
  logic                cont_q;
  logic                stop_pend, stop_pend_nxt;
  logic [NCH-1:0]      tab_en;
  logic [3:0]          tab_tap [NCH];
  logic [3:0]          tap_nxt;
  logic [CW-1:0]       ch_nxt;
  logic                scan_done_nxt;
  logic                found;
  logic [CW-1:0]       sel;

  // Lowest enabled channel at or above ptr; descending loop leaves the lowest hit in sel.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (tab_en[i] && ((CW+1)'(i) >= ptr)) begin
        found = 1'b1;
        sel   = CW'(i);
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    ptr_nxt       = ptr;
    stop_pend_nxt = stop_pend;
    tap_nxt       = tap_sel;
    ch_nxt        = ch_idx;
    scan_done_nxt = 1'b0;
    unique case (state)
      S_IDLE: begin
        stop_pend_nxt = 1'b0;
        if (start && !stop) begin
          state_nxt = S_FIND;
          ptr_nxt   = '0;
        end
      end
      S_FIND: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (found) begin
          ch_nxt    = sel;
          tap_nxt   = tab_tap[sel];
          ptr_nxt   = {1'b0, sel} + PTR_ONE;
          cnt_nxt   = CNT_W'(LORST_CYC - 1);
          state_nxt = S_LORST;
        end else begin
          scan_done_nxt = 1'b1;
          if (cont_q && |tab_en) begin
            ptr_nxt   = '0;
            state_nxt = S_FIND;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_LORST: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (cnt == '0) begin
          if (settle_q != '0) begin
            state_nxt = S_SETTLE;
            cnt_nxt   = CNT_W'(settle_q) - CNT_ONE;
          end else begin
            state_nxt = S_DWELL;
            cnt_nxt   = CNT_W'(dwell_q) - CNT_ONE;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_SETTLE: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (cnt == '0) begin
          state_nxt = S_DWELL;
          cnt_nxt   = CNT_W'(dwell_q) - CNT_ONE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_DWELL: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (cnt == '0) begin
          state_nxt = S_HANDOFF;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_HANDOFF: begin
        // A stop here only takes effect once the accumulator has acked.
        if (stop) stop_pend_nxt = 1'b1;
        if (done_ack) state_nxt = (stop_pend || stop) ? S_IDLE : S_FIND;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ptr        <= '0;
      dwell_q    <= '0;
      settle_q   <= '0;
      cont_q     <= 1'b0;
      stop_pend  <= 1'b0;
      lo_rst     <= 1'b1;
      tap_sel    <= '0;
      ch_idx     <= '0;
      meas_valid <= 1'b0;
      done_req   <= 1'b0;
      busy       <= 1'b0;
      scan_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ptr        <= ptr_nxt;
      stop_pend  <= stop_pend_nxt;
      tap_sel    <= tap_nxt;
      ch_idx     <= ch_nxt;
      scan_done  <= scan_done_nxt;
      lo_rst     <= (state_nxt == S_IDLE) || (state_nxt == S_LORST);
      meas_valid <= (state_nxt == S_DWELL);
      done_req   <= (state_nxt == S_HANDOFF);
      busy       <= (state_nxt != S_IDLE);
      if (state == S_IDLE && start && !stop) begin
        dwell_q  <= (dwell == '0) ? DWELL_W'(1) : dwell;
        settle_q <= settle;
        cont_q   <= cont;
      end
    end
  end

  // NOTE: the channel table is a small register file that must come out of reset cleared,
  // so unlike a RAM it is reset explicitly.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      tab_en <= '0;
      for (int i = 0; i < NCH; i++) tab_tap[i] <= '0;
    end else if (cfg_we) begin
      tab_en[cfg_addr]  <= cfg_en;
      tab_tap[cfg_addr] <= cfg_tap;
    end
  end

endmodule

// File: tb/tb_lo_channel_sequencer.sv
// Directed bench for lo_channel_sequencer: a per-cycle vector table for a full
// two-channel scan plus hand-written sequences for ack, stop, cont and reset corners.
module tb_lo_channel_sequencer;

  logic        clk = 1'b0;
  logic        rstb;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic        cfg_en;
  logic [3:0]  cfg_tap;
  logic [15:0] dwell;
  logic [7:0]  settle;
  logic        cont, start, stop, done_ack;
  logic        lo_rst, meas_valid, done_req, busy, scan_done;
  logic [3:0]  tap_sel, ch_idx;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lo_channel_sequencer dut (
    .clk(clk), .rstb(rstb), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_en(cfg_en),
    .cfg_tap(cfg_tap), .dwell(dwell), .settle(settle), .cont(cont), .start(start),
    .stop(stop), .done_ack(done_ack), .lo_rst(lo_rst), .tap_sel(tap_sel),
    .ch_idx(ch_idx), .meas_valid(meas_valid), .done_req(done_req), .busy(busy),
    .scan_done(scan_done)
  );

  // {lo_rst, tap_sel, ch_idx, meas_valid, done_req, busy, scan_done}
  function automatic logic [12:0] pk(input logic lo, input logic [3:0] tap,
      input logic [3:0] ch, input logic mv, input logic dr, input logic bsy, input logic sd);
    return {lo, tap, ch, mv, dr, bsy, sd};
  endfunction

  function automatic logic [12:0] outs();
    return pk(lo_rst, tap_sel, ch_idx, meas_valid, done_req, busy, scan_done);
  endfunction

  typedef struct {
    logic        start;
    logic        ack;
    logic [12:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int n, input logic st, input logic ak, input logic [12:0] e);
    vec_t v;
    v.start = st; v.ack = ak; v.exp = e;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      0:       return done_req;
      1:       return meas_valid;
      2:       return !busy;
      default: return lo_rst && busy;
    endcase
  endfunction

  task automatic wait_for(input string name, input int sel, input int max);
    int i = 0;
    while (!cond(sel) && i < max) begin
      tick();
      i++;
    end
    check(name, 32'(cond(sel)), 32'd1);
  endtask

  task automatic wr(input logic [3:0] a, input logic en, input logic [3:0] tap);
    cfg_we = 1'b1; cfg_addr = a; cfg_en = en; cfg_tap = tap;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rstb = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_en = 1'b0; cfg_tap = '0;
    dwell = 16'd4; settle = 8'd2; cont = 1'b0; start = 1'b0; stop = 1'b0; done_ack = 1'b1;
    tick(); tick();
    check("reset_outputs", 32'(outs()), 32'(pk(1, 0, 0, 0, 0, 0, 0)));
    rstb = 1'b1;
    tick();
    wr(4'd2, 1'b1, 4'd5);
    wr(4'd7, 1'b1, 4'd9);
    check("idle_after_cfg", 32'(outs()), 32'(pk(1, 0, 0, 0, 0, 0, 0)));

    // Full scan, ack held high: FIND, 3 LORST, 2 SETTLE, 4 DWELL, 1 HANDOFF per channel.
    add(1, 1, 1, pk(0, 0, 0, 0, 0, 1, 0));
    add(3, 0, 1, pk(1, 5, 2, 0, 0, 1, 0));
    add(2, 0, 1, pk(0, 5, 2, 0, 0, 1, 0));
    add(4, 0, 1, pk(0, 5, 2, 1, 0, 1, 0));
    add(1, 0, 1, pk(0, 5, 2, 0, 1, 1, 0));
    add(1, 0, 1, pk(0, 5, 2, 0, 0, 1, 0));
    add(3, 0, 1, pk(1, 9, 7, 0, 0, 1, 0));
    add(2, 0, 1, pk(0, 9, 7, 0, 0, 1, 0));
    add(4, 0, 1, pk(0, 9, 7, 1, 0, 1, 0));
    add(1, 0, 1, pk(0, 9, 7, 0, 1, 1, 0));
    add(1, 0, 1, pk(0, 9, 7, 0, 0, 1, 0));
    add(1, 0, 1, pk(1, 9, 7, 0, 0, 0, 1));
    add(1, 0, 1, pk(1, 9, 7, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      start = tbl[i].start;
      done_ack = tbl[i].ack;
      tick();
      check($sformatf("scan_vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end
    start = 1'b0;

    // Ack delayed 10 cycles: done_req holds, ch7 FIND the cycle after the ack edge.
    done_ack = 1'b0;
    kick();
    wait_for("wait_req_delayed", 0, 50);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("req_hold%0d", i), 32'(done_req), 32'd1);
      if (i == 9) done_ack = 1'b1;
      tick();
    end
    check("find_after_ack", 32'(outs()), 32'(pk(0, 5, 2, 0, 0, 1, 0)));
    tick();
    check("ch7_lorst", 32'(outs()), 32'(pk(1, 9, 7, 0, 0, 1, 0)));
    wait_for("idle_after_delayed", 2, 50);

    // Stop while done_req is up: held until ack, then IDLE without another FIND.
    done_ack = 1'b0;
    kick();
    wait_for("wait_req_stop", 0, 50);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("req_after_stop", 32'(done_req), 32'd1);
    tick(); tick(); tick();
    check("req_still_held", 32'(done_req), 32'd1);
    done_ack = 1'b1;
    tick();
    check("stop_ack_idle", 32'(outs()), 32'(pk(1, 5, 2, 0, 0, 0, 0)));
    tick();
    check("stop_no_find", 32'(busy), 32'd0);

    // Table write to ch7 mid-visit of ch2 leaves ch2 untouched and is seen at ch7's FIND.
    kick();
    wait_for("wait_dwell_ch2", 1, 50);
    wr(4'd7, 1'b1, 4'd3);
    check("ch2_unaffected", 32'(outs()), 32'(pk(0, 5, 2, 1, 0, 1, 0)));
    tick();
    wait_for("wait_lorst_ch7", 3, 50);
    check("ch7_new_tap", 32'(outs()), 32'(pk(1, 3, 7, 0, 0, 1, 0)));
    wait_for("idle_after_write", 2, 50);

    // dwell=0 behaves as a one-cycle window.
    wr(4'd7, 1'b0, 4'd3);
    dwell = 16'd0;
    kick();
    wait_for("wait_dwell0", 1, 50);
    tick();
    check("dwell0_one_cycle", 32'({meas_valid, done_req}), 32'b01);
    wait_for("idle_dwell0", 2, 50);

    // settle=0: DWELL directly after the third LORST cycle.
    dwell = 16'd2; settle = 8'd0;
    kick();
    wait_for("wait_lorst_s0", 3, 50);
    tick(); tick();
    check("lorst_third", 32'({lo_rst, meas_valid}), 32'b10);
    tick();
    check("settle0_dwell", 32'({lo_rst, meas_valid}), 32'b01);
    wait_for("idle_settle0", 2, 50);

    // Reset in SETTLE.
    settle = 8'd5;
    kick();
    wait_for("wait_lorst_s5", 3, 50);
    tick(); tick(); tick();
    check("in_settle", 32'({lo_rst, meas_valid, busy}), 32'b001);
    rstb = 1'b0;
    tick();
    check("reset_mid_settle", 32'(outs()), 32'(pk(1, 0, 0, 0, 0, 0, 0)));
    rstb = 1'b1;
    tick();

    // Cleared table with cont=1: one FIND, one scan_done, back to IDLE.
    cont = 1'b1; dwell = 16'd4; settle = 8'd2;
    kick();
    check("empty_find", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 1, 0)));
    tick();
    check("empty_scan_done", 32'(outs()), 32'(pk(1, 0, 0, 0, 0, 0, 1)));
    tick();
    check("empty_idle", 32'(outs()), 32'(pk(1, 0, 0, 0, 0, 0, 0)));

    // cont=1, only ch0: revisits with scan_done between; stop in DWELL aborts.
    wr(4'd0, 1'b1, 4'd6);
    done_ack = 1'b1;
    kick();
    wait_for("wait_req_cont", 0, 50);
    tick();
    check("cont_find_end", 32'(outs()), 32'(pk(0, 6, 0, 0, 0, 1, 0)));
    tick();
    check("cont_scan_done", 32'(outs()), 32'(pk(0, 6, 0, 0, 0, 1, 1)));
    tick();
    check("cont_revisit", 32'(outs()), 32'(pk(1, 6, 0, 0, 0, 1, 0)));
    wait_for("wait_dwell_cont", 1, 50);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_dwell_idle", 32'(outs()), 32'(pk(1, 6, 0, 0, 0, 0, 0)));
    tick(); tick(); tick();
    check("stop_dwell_quiet", 32'(outs()), 32'(pk(1, 6, 0, 0, 0, 0, 0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lo_channel_sequencer.md
Name: lo_channel_sequencer

Overview:
- Time-multiplexes the quadrature LO across up to NCH analysis channels.
- Each channel has a programmable divider tap (0..15) and an enable bit.
- The sequencer walks the enabled channels in order. For each one it:
  - drives the tap select to the clock-tree mux,
  - pulses the LO reset,
  - waits a settle interval,
  - opens a measurement window,
  - hands the result off to the downstream accumulator over a req/ack handshake.
- Sits between the register interface and the LO/clock tree.

Parameters:
- NCH, 16, number of channels; channel index width CW = clog2(NCH).
- DWELL_W, 16, width of the dwell counter.
- SETTLE_W, 8, width of the settle counter.
- LORST_CYC, 3, cycles lo_rst is held high per channel switch. Minimum 3, because the LO reset synchronizer needs 2 edges.

Ports:
- clk, input, 1, system clock; all state updates on posedge.
- rstb, input, 1, synchronous active-low reset.
- cfg_we, input, 1, channel table write strobe.
- cfg_addr, input, CW, channel table write address.
- cfg_en, input, 1, enable bit written to the addressed channel.
- cfg_tap, input, 4, divider tap written to the addressed channel.
- dwell, input, DWELL_W, measurement window length in cycles; sampled on start.
- settle, input, SETTLE_W, settle length in cycles; sampled on start.
- cont, input, 1, continuous mode; sampled on start.
- start, input, 1, begin a scan (ignored unless IDLE).
- stop, input, 1, abort the scan.
- done_ack, input, 1, downstream acknowledge of done_req.
- lo_rst, output, 1, active-high reset to the LO (rst_ext).
- tap_sel, output, 4, divider tap to the clock-tree mux.
- ch_idx, output, CW, channel currently being served.
- meas_valid, output, 1, measurement window open.
- done_req, output, 1, channel result ready for the accumulator.
- busy, output, 1, high in every state except IDLE.
- scan_done, output, 1, one-cycle pulse at the end of each pass over the table.

Behaviour:
- All outputs are registered.
- Reset (rstb=0 at posedge):
  - state=IDLE, lo_rst=1, tap_sel=0, ch_idx=0, meas_valid=0, done_req=0, busy=0, scan_done=0.
  - Channel table cleared: all en=0, all tap=0.
- Reset mid-operation aborts immediately, with no handshake completion.
- Table write: on cfg_we, the entry at cfg_addr is updated at the posedge. Writes are legal at any time.
  - The tap and enable are consumed when the channel is next selected in FIND.
  - A write to the channel currently being served does not affect the current visit.
- States:
  - IDLE:
    - lo_rst=1.
    - On start=1: latch dwell, settle, cont; set ptr=0; go to FIND.
    - dwell=0 is treated as 1.
  - FIND (exactly 1 cycle):
    - Select the lowest enabled channel with index >= ptr.
    - If found: ch_idx=that channel, tap_sel=its tap, ptr=channel+1; go to LORST.
    - If none found (end of table):
      - scan_done pulses in the next cycle.
      - If cont=1 and at least one channel is enabled: ptr=0 and FIND again.
      - Otherwise: go to IDLE.
    - An all-disabled table with cont=1 also returns to IDLE.
  - LORST:
    - lo_rst=1 for LORST_CYC cycles.
    - Then SETTLE if settle>0, else DWELL.
  - SETTLE: lo_rst=0 for settle cycles, then DWELL.
  - DWELL: lo_rst=0, meas_valid=1 for exactly dwell cycles, then HANDOFF.
  - HANDOFF:
    - done_req=1 and held until done_ack is sampled high while done_req=1.
    - On that edge: done_req=0; go to FIND.
    - An ack arriving before done_req is ignored.
- Per-channel latency from FIND entry to the first meas_valid cycle = 1 + LORST_CYC + settle.
- stop=1:
  - In LORST, SETTLE or DWELL: next state is IDLE, with meas_valid=0, lo_rst=1. No done_req is issued and no scan_done.
  - In HANDOFF: the stop is latched and honoured after ack; the state then goes to IDLE instead of FIND.
  - In FIND: next state is IDLE.
  - In IDLE: no effect.
- start and stop together in IDLE: stop wins and the state stays IDLE.
- start while busy: ignored.
- tap_sel and ch_idx hold their last values in IDLE.
- ptr wrap: ptr equal to NCH means end of table. ptr is CW+1 bits wide.

Test Plan:
- Reset, then enable ch2 (tap 5) and ch7 (tap 9); dwell=4, settle=2, cont=0; start, with ack held at 1:
  - FIND, then lo_rst=1 for 3 cycles, settle 2, meas_valid for 4 cycles with ch_idx=2 and tap_sel=5, done_req 1 cycle.
  - The same sequence for ch_idx=7, tap_sel=9.
  - scan_done pulse, then IDLE, busy=0.
- Same config with done_ack delayed 10 cycles: done_req stays high for those 10 cycles, and ch7 FIND occurs the cycle after the ack edge.
- All channels disabled, start with cont=1: busy for 1 cycle (FIND), a single scan_done pulse, back to IDLE.
- cont=1 with only ch0 enabled: ch0 is served repeatedly, and a scan_done pulse occurs between visits. Assert stop during DWELL: next cycle IDLE, meas_valid=0, lo_rst=1, no done_req.
- stop asserted while done_req=1 with the ack delayed: done_req is held until the ack, then IDLE with no further FIND.
- Write ch7 tap=3 while ch2 is in DWELL: ch2 is unaffected and ch7 is served with tap_sel=3. Then dwell=0: meas_valid lasts exactly 1 cycle. Then settle=0: DWELL starts immediately after LORST. Finally, rstb low during SETTLE: all outputs at reset values and the table cleared.
